// File: rtl/ahbl_defs.sv
// AHB-lite encodings shared by the simple master and its helpers.
package ahbl_defs;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // Error-response tracking: RUN normally, ERR_HOLD for the second cycle
    // of a two-cycle ERROR response, while the pending request is held back.
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_ERR_HOLD = 1'b1
    } err_state_e;

endpackage

// File: rtl/ahb_byte_lanes.sv
// Byte-lane steering: replicates LSB-aligned write data across all lanes of
// the bus, and pulls read data for a sized access down to bit 0 with the
// bytes above the access size forced to zero. Purely combinational.
module ahb_byte_lanes #(
    parameter int W_DATA = 32
) (
    input  logic [W_DATA-1:0]                 wdata_i,
    input  logic [2:0]                        size_i,
    input  logic [$clog2(W_DATA/8)-1:0]       lo_i,
    input  logic [W_DATA-1:0]                 hrdata_i,
    output logic [W_DATA-1:0]                 wdata_rep_o,
    output logic [W_DATA-1:0]                 rdata_ext_o
);

    localparam int LANES = W_DATA / 8;
    localparam int LOG_L = $clog2(LANES);

    int                      sz_n;
    int                      nbytes;
    logic [W_DATA-1:0]       shifted;
    logic [LANES-1:0][7:0]   wrep;
    logic [LANES-1:0][7:0]   rext;

    // Oversized requests are misaligned and never reach the bus; clamping
    // keeps the lane arithmetic inside the data word for them.
    always_comb begin
        sz_n   = (int'(size_i) > LOG_L) ? LOG_L : int'(size_i);
        nbytes = 1 << sz_n;
    end

    assign shifted = hrdata_i >> {lo_i, 3'b000};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Lane i repeats source byte (i mod access-bytes).
        assign wrep[i] = wdata_i[(i % nbytes) * 8 +: 8];
        // Only the lowest access-size bytes of the shifted word survive.
        assign rext[i] = (i < nbytes) ? shifted[i * 8 +: 8] : 8'h00;
    end

    assign wdata_rep_o = wrep;
    assign rdata_ext_o = rext;

endmodule

// File: rtl/ahb_simple_master.sv
// Single-port AHB-lite master. Each accepted request becomes one SINGLE
// NONSEQ transfer; the address phase comes straight from the request port so
// the next address overlaps the current data phase. Responses return in
// order, one per request, with read data lane-extracted to the LSBs.
module ahb_simple_master
    import ahbl_defs::*;
#(
    parameter int W_DATA = 32,
    parameter int W_ADDR = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W_ADDR-1:0] req_addr,
    input  logic              req_write,
    input  logic [2:0]        req_size,
    input  logic [W_DATA-1:0] req_wdata,

    output logic              resp_valid,
    output logic              resp_err,
    output logic [W_DATA-1:0] resp_rdata,

    output logic [W_ADDR-1:0] ahblm_haddr,
    output logic              ahblm_hwrite,
    output logic [1:0]        ahblm_htrans,
    output logic [2:0]        ahblm_hsize,
    output logic [2:0]        ahblm_hburst,
    output logic [3:0]        ahblm_hprot,
    output logic              ahblm_hmastlock,
    output logic [W_DATA-1:0] ahblm_hwdata,
    input  logic              ahblm_hready,
    input  logic              ahblm_hresp,
    input  logic [W_DATA-1:0] ahblm_hrdata
);

    localparam int LANES = W_DATA / 8;
    localparam int LOG_L = $clog2(LANES);

    err_state_e          state_q;
    logic                err_hold;

    logic                dph_active_q;
    logic                dph_write_q;
    logic                dph_local_err_q;
    logic [2:0]          dph_size_q;
    logic [LOG_L-1:0]    dph_lo_q;
    logic [W_DATA-1:0]   hwdata_q;

    logic                aligned;
    logic                accept;
    logic                complete;
    logic [W_DATA-1:0]   wdata_rep;
    logic [W_DATA-1:0]   rdata_ext;

    assign err_hold = (state_q == ST_ERR_HOLD);

    // Alignment check: low size bits of the address must be zero; a size
    // wider than the bus can never be aligned.
    always_comb begin
        aligned = 1'b1;
        if (int'(req_size) > LOG_L) begin
            aligned = 1'b0;
        end else begin
            for (int b = 0; b < LOG_L; b++) begin
                if (b < int'(req_size) && req_addr[b]) aligned = 1'b0;
            end
        end
    end

    // Address phase follows the request port directly. A misaligned request
    // is still accepted, but only ever shows IDLE on the bus.
    assign req_ready       = ahblm_hready && !err_hold;
    assign accept          = req_valid && req_ready;
    assign ahblm_htrans    = (req_valid && aligned && !err_hold) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahblm_haddr     = req_addr;
    assign ahblm_hwrite    = req_write;
    assign ahblm_hsize     = req_size;
    assign ahblm_hburst    = HBURST_SINGLE;
    assign ahblm_hprot     = HPROT_DEFAULT;
    assign ahblm_hmastlock = 1'b0;
    assign ahblm_hwdata    = hwdata_q;

    ahb_byte_lanes #(
        .W_DATA (W_DATA)
    ) u_lanes (
        .wdata_i     (req_wdata),
        .size_i      (dph_size_q),
        .lo_i        (dph_lo_q),
        .hrdata_i    (ahblm_hrdata),
        .wdata_rep_o (wdata_rep),
        .rdata_ext_o (rdata_ext)
    );

    // Replication uses the request size at acceptance time, so a second
    // instance would be needed if size came from the data phase; instead the
    // write path reuses the lane helper with the request size below.
    logic [W_DATA-1:0] wdata_rep_req;
    logic [W_DATA-1:0] rdata_unused;

    ahb_byte_lanes #(
        .W_DATA (W_DATA)
    ) u_wlanes (
        .wdata_i     (req_wdata),
        .size_i      (req_size),
        .lo_i        (req_addr[LOG_L-1:0]),
        .hrdata_i    ('0),
        .wdata_rep_o (wdata_rep_req),
        .rdata_ext_o (rdata_unused)
    );

    // Data-phase registers advance only on hready; a wait state freezes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_active_q    <= 1'b0;
            dph_write_q     <= 1'b0;
            dph_local_err_q <= 1'b0;
            dph_size_q      <= 3'd0;
            dph_lo_q        <= '0;
            hwdata_q        <= '0;
        end else if (ahblm_hready) begin
            dph_active_q <= accept;
            if (accept) begin
                dph_write_q     <= req_write;
                dph_local_err_q <= !aligned;
                dph_size_q      <= req_size;
                dph_lo_q        <= req_addr[LOG_L-1:0];
                hwdata_q        <= wdata_rep_req;
            end
        end
    end

    // Two-cycle ERROR: first cycle (hresp && !hready) arms the hold, which
    // blocks issue of the next request until hready completes the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (dph_active_q && !dph_local_err_q && ahblm_hresp && !ahblm_hready)
                        state_q <= ST_ERR_HOLD;
                end
                ST_ERR_HOLD: begin
                    if (ahblm_hready) state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // Response is produced in the cycle the data phase completes.
    assign complete   = dph_active_q && ahblm_hready;
    assign resp_valid = complete;
    assign resp_err   = complete && (dph_local_err_q || ahblm_hresp);
    assign resp_rdata = (complete && !dph_write_q && !resp_err) ? rdata_ext : '0;

    // The data-phase instance only serves reads; its write output is unused.
    logic unused_ok;
    assign unused_ok = ^{wdata_rep, rdata_unused};

endmodule

// File: tb/tb_ahb_simple_master.sv
// Directed bench for ahb_simple_master with a small zero-wait SRAM slave.
// hready/hresp are driven directly by each scenario; the slave memory
// reinitialises to 0xC0DE0000|word_index on reset.
module tb_ahb_simple_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hmastlock, hready, hresp;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ahb_simple_master #(.W_DATA(32), .W_ADDR(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans),
        .ahblm_hsize(hsize), .ahblm_hburst(hburst), .ahblm_hprot(hprot),
        .ahblm_hmastlock(hmastlock), .ahblm_hwdata(hwdata),
        .ahblm_hready(hready), .ahblm_hresp(hresp), .ahblm_hrdata(hrdata)
    );

    // SRAM slave model
    logic [31:0] mem [0:63];
    logic        sl_act, sl_write;
    logic [31:0] sl_addr;
    logic [2:0]  sl_size;

    assign hrdata = mem[sl_addr[7:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE0000 | i;
            sl_act <= 1'b0; sl_write <= 1'b0; sl_addr <= '0; sl_size <= '0;
        end else if (hready) begin
            if (sl_act && sl_write && !hresp)
                for (int b = 0; b < 4; b++)
                    if (b >= int'(sl_addr[1:0]) && b < int'(sl_addr[1:0]) + (1 << sl_size))
                        mem[sl_addr[7:2]][b*8 +: 8] <= hwdata[b*8 +: 8];
            sl_act   <= (htrans == 2'b10);
            sl_write <= hwrite;
            sl_addr  <= haddr;
            sl_size  <= hsize;
        end
    end

    task automatic drive(input logic v, input logic w, input logic [31:0] a,
                         input logic [2:0] s, input logic [31:0] d);
        req_valid = v; req_write = w; req_addr = a; req_size = s; req_wdata = d;
    endtask

    task automatic bus(input logic rdy, input logic rsp);
        hready = rdy; hresp = rsp;
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        n_cmp++; if (htrans !== 2'b00) begin n_bad++; $display("FAIL rst_htrans: got %0h want 0", htrans); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %0b want 0", resp_valid); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_rerr: got %0b want 0", resp_err); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
        n_cmp++; if (hwdata !== 32'h0) begin n_bad++; $display("FAIL rst_hwdata: got %h want 0", hwdata); end
        n_cmp++; if ({hburst, hprot, hmastlock} !== {3'b000, 4'b0011, 1'b0}) begin n_bad++; $display("FAIL rst_consts: got %b %b %b want 000 0011 0", hburst, hprot, hmastlock); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        @(negedge clk); drive(1, 1, 32'h100, 3'd2, 32'hDEADBEEF); #1;
        n_cmp++; if (htrans !== 2'b10) begin n_bad++; $display("FAIL wr_htrans: got %0h want 2", htrans); end
        n_cmp++; if ({haddr, hwrite, hsize} !== {32'h100, 1'b1, 3'd2}) begin n_bad++; $display("FAIL wr_aphase: got %h %b %0d want 100 1 2", haddr, hwrite, hsize); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_rvalid0: got %0b want 0", resp_valid); end
        @(negedge clk); drive(1, 0, 32'h100, 3'd2, 32'h0); #1;
        n_cmp++; if (htrans !== 2'b10) begin n_bad++; $display("FAIL rd_htrans: got %0h want 2", htrans); end
        n_cmp++; if (hwdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_hwdata: got %h want deadbeef", hwdata); end
        n_cmp++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin n_bad++; $display("FAIL wr_resp: got %b %b %h want 1 0 0", resp_valid, resp_err, resp_rdata); end
        @(negedge clk); drive(0, 0, 32'h0, 3'd0, 32'h0); #1;
        n_cmp++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL rd_resp: got %b %b %h want 1 0 deadbeef", resp_valid, resp_err, resp_rdata); end
        @(negedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_rvalid_end: got %0b want 0", resp_valid); end
    endtask

    task automatic test_byte_lanes;
        @(negedge clk); drive(1, 1, 32'h103, 3'd0, 32'hFFFFFF5A); #1;
        n_cmp++; if ({htrans, hsize} !== {2'b10, 3'd0}) begin n_bad++; $display("FAIL byte_aphase: got %0h %0d want 2 0", htrans, hsize); end
        @(negedge clk); drive(1, 0, 32'h103, 3'd0, 32'h0); #1;
        n_cmp++; if (hwdata !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL byte_hwdata: got %h want 5a5a5a5a", hwdata); end
        @(negedge clk); drive(1, 0, 32'h102, 3'd1, 32'h0); #1;
        n_cmp++; if ({resp_valid, resp_rdata} !== {1'b1, 32'h0000005A}) begin n_bad++; $display("FAIL byte_rdata: got %b %h want 1 0000005a", resp_valid, resp_rdata); end
        @(negedge clk); drive(0, 0, 32'h0, 3'd0, 32'h0); #1;
        n_cmp++; if ({resp_valid, resp_rdata} !== {1'b1, 32'h00005AAD}) begin n_bad++; $display("FAIL half_rdata: got %b %h want 1 00005aad", resp_valid, resp_rdata); end
    endtask

    task automatic test_wait_states;
        @(negedge clk); drive(1, 0, 32'h100, 3'd2, 32'h0); bus(1, 0); #1;
        n_cmp++; if (htrans !== 2'b10) begin n_bad++; $display("FAIL ws_htrans0: got %0h want 2", htrans); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(1, 0, 32'h104, 3'd2, 32'h0); bus(0, 0); #1;
            n_cmp++; if ({htrans, haddr, req_ready, resp_valid} !== {2'b10, 32'h104, 1'b0, 1'b0}) begin n_bad++; $display("FAIL ws_hold%0d: got %0h %h %b %b want 2 104 0 0", k, htrans, haddr, req_ready, resp_valid); end
        end
        @(negedge clk); bus(1, 0); #1;
        n_cmp++; if ({resp_valid, resp_err, resp_rdata, req_ready} !== {1'b1, 1'b0, 32'h5AADBEEF, 1'b1}) begin n_bad++; $display("FAIL ws_resp: got %b %b %h %b want 1 0 5aadbeef 1", resp_valid, resp_err, resp_rdata, req_ready); end
        @(negedge clk); drive(0, 0, 32'h0, 3'd0, 32'h0); #1;
        n_cmp++; if ({resp_valid, resp_rdata} !== {1'b1, 32'hC0DE0001}) begin n_bad++; $display("FAIL ws_next: got %b %h want 1 c0de0001", resp_valid, resp_rdata); end
        @(negedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL ws_end: got %0b want 0", resp_valid); end
    endtask

    task automatic test_error;
        @(negedge clk); drive(1, 1, 32'h108, 3'd2, 32'h11223344); bus(1, 0); #1;
        n_cmp++; if (htrans !== 2'b10) begin n_bad++; $display("FAIL err_htrans0: got %0h want 2", htrans); end
        @(negedge clk); drive(1, 0, 32'h10C, 3'd2, 32'h0); bus(0, 1); #1;
        n_cmp++; if ({req_ready, resp_valid} !== 2'b00) begin n_bad++; $display("FAIL err_cyc1: got %b %b want 0 0", req_ready, resp_valid); end
        @(negedge clk); bus(1, 1); #1;
        n_cmp++; if ({htrans, req_ready} !== {2'b00, 1'b0}) begin n_bad++; $display("FAIL err_hold: got %0h %b want 0 0", htrans, req_ready); end
        n_cmp++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b1, 32'h0}) begin n_bad++; $display("FAIL err_resp: got %b %b %h want 1 1 0", resp_valid, resp_err, resp_rdata); end
        @(negedge clk); bus(1, 0); #1;
        n_cmp++; if ({htrans, req_ready, resp_valid} !== {2'b10, 1'b1, 1'b0}) begin n_bad++; $display("FAIL err_reissue: got %0h %b %b want 2 1 0", htrans, req_ready, resp_valid); end
        @(negedge clk); drive(1, 0, 32'h108, 3'd2, 32'h0); #1;
        n_cmp++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'hC0DE0003}) begin n_bad++; $display("FAIL err_read: got %b %b %h want 1 0 c0de0003", resp_valid, resp_err, resp_rdata); end
        @(negedge clk); drive(0, 0, 32'h0, 3'd0, 32'h0); #1;
        n_cmp++; if (resp_rdata !== 32'hC0DE0002) begin n_bad++; $display("FAIL err_nowrite: got %h want c0de0002", resp_rdata); end
    endtask

    task automatic test_misaligned;
        @(negedge clk); drive(1, 0, 32'h101, 3'd1, 32'h0); #1;
        n_cmp++; if ({htrans, req_ready} !== {2'b00, 1'b1}) begin n_bad++; $display("FAIL mis_half_aphase: got %0h %b want 0 1", htrans, req_ready); end
        @(negedge clk); drive(1, 0, 32'h100, 3'd3, 32'h0); #1;
        n_cmp++; if (htrans !== 2'b00) begin n_bad++; $display("FAIL mis_size_htrans: got %0h want 0", htrans); end
        n_cmp++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b1, 32'h0}) begin n_bad++; $display("FAIL mis_half_resp: got %b %b %h want 1 1 0", resp_valid, resp_err, resp_rdata); end
        @(negedge clk); drive(0, 0, 32'h0, 3'd0, 32'h0); #1;
        n_cmp++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b1, 32'h0}) begin n_bad++; $display("FAIL mis_size_resp: got %b %b %h want 1 1 0", resp_valid, resp_err, resp_rdata); end
        @(negedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL mis_end: got %0b want 0", resp_valid); end
    endtask

    task automatic test_reset_midflight;
        @(negedge clk); drive(1, 1, 32'h110, 3'd2, 32'hCAFEF00D); bus(1, 0);
        @(negedge clk); drive(1, 0, 32'h110, 3'd2, 32'hCAFEF00D); #1;
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL mr_wresp: got %0b want 1", resp_valid); end
        @(negedge clk); drive(0, 0, 32'h0, 3'd0, 32'h0); bus(0, 0); #1;
        n_cmp++; if (hwdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mr_hwdata_pre: got %h want cafef00d", hwdata); end
        rst_n = 1'b0; bus(1, 0); #1;
        n_cmp++; if ({resp_valid, htrans, hwdata, req_ready} !== {1'b0, 2'b00, 32'h0, 1'b1}) begin n_bad++; $display("FAIL mr_async: got %b %0h %h %b want 0 0 0 1", resp_valid, htrans, hwdata, req_ready); end
        @(negedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL mr_noresp: got %0b want 0", resp_valid); end
        rst_n = 1'b1;
        @(negedge clk); drive(1, 0, 32'h110, 3'd2, 32'h0); #1;
        n_cmp++; if (htrans !== 2'b10) begin n_bad++; $display("FAIL mr_issue: got %0h want 2", htrans); end
        @(negedge clk); drive(0, 0, 32'h0, 3'd0, 32'h0); #1;
        n_cmp++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'hC0DE0004}) begin n_bad++; $display("FAIL mr_resp: got %b %b %h want 1 0 c0de0004", resp_valid, resp_err, resp_rdata); end
    endtask

    initial begin
        drive(0, 0, 32'h0, 3'd0, 32'h0);
        bus(1, 0);
        test_reset;
        test_write_read;
        test_byte_lanes;
        test_wait_states;
        test_error;
        test_misaligned;
        test_reset_midflight;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
